// File: rtl/cnn_mem_pkg.sv
// Shared types, default widths and index helpers for the CNN memory subsystem.
// Imported by the RAM port arbiter and its round-robin picker.
package cnn_mem_pkg;

    localparam int CNN_ADDR_W = 16;
    localparam int CNN_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE
    } arb_state_t;

    typedef logic signed [CNN_DATA_W-1:0] word_t;

    // Wraps an index that can overshoot the requester count by less than n.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, with
// wrap-around; any_req_o flags that at least one request is pending.
module rr_picker
    import cnn_mem_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] winner_o,
    output logic             any_req_o
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        winner_o  = '0;
        any_req_o = |req_i;
        // Scan from the farthest offset down so the nearest set bit wins last.
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (req_i[rr_wrap(int'(ptr_i) + off, N_REQ)]) begin
                winner_o = PTR_W'(rr_wrap(int'(ptr_i) + off, N_REQ));
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the single CNN RAM port between N_REQ requesters.
// Optional access watchdog with sticky err flag: define RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter
    import cnn_mem_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int ADDR_W      = CNN_ADDR_W,
    parameter int DATA_W      = CNN_DATA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_done,
    output logic                     err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [PTR_W-1:0]  pick;
    logic              any_req;
    logic              timeout;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .winner_o  (pick),
        .any_req_o (any_req)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d     = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = req_we[pick];
                    mem_addr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
                    mem_wdata_d = req_wdata[int'(pick)*DATA_W +: DATA_W];
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // Operands stay frozen; only completion or the watchdog ends the access.
                if (mem_done || timeout) begin
                    mem_en_d        = 1'b0;
                    gnt_d           = '0;
                    done_d[owner_q] = 1'b1;
                    if (mem_done && !mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    ptr_d   = PTR_W'(rr_wrap(int'(owner_q) + 1, N_REQ));
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the reset here is synchronous and active-high, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values computed by the comb block.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;

    // Fires in the TIMEOUT_CYC-th access cycle unless the RAM answers in it.
    assign timeout = (state_q == ACCESS) && !mem_done && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmr_d = '0;
        err_d = err_q | timeout;
        if (state_q == ACCESS && !timeout) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // Without the watchdog an access waits on mem_done indefinitely.
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: transaction-level reference model,
// RAM responder, directed scenarios and a randomized contention phase.
module tb_ram_port_arbiter;

    localparam int N_REQ       = 3;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int TIMEOUT_CYC = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req, req_we, gnt, done;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]       rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    busy, mem_en, mem_we, mem_done, err;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .N_REQ       (N_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM fixture ----------------
    logic [DATA_W-1:0] ram [logic [ADDR_W-1:0]];
    int  lat      = 0;
    bit  hang     = 0;
    bit  noise    = 0;
    bit  rnd_mode = 0;
    bit  chk_en   = 0;
    int  wait_cnt = 0;
    bit  sent     = 0;

    function automatic logic [DATA_W-1:0] ram_rd(input logic [ADDR_W-1:0] a);
        return ram.exists(a) ? ram[a] : '0;
    endfunction

    always @(negedge clk) begin
        if (mem_en) begin
            if (!sent && !hang && wait_cnt >= lat) begin
                mem_done = 1'b1;
                sent     = 1'b1;
                if (mem_we) ram[mem_addr] = mem_wdata;
                else        mem_rdata     = ram_rd(mem_addr);
            end else begin
                mem_done = 1'b0;
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            sent     = 1'b0;
            mem_done = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (noise)    mem_rdata = DATA_W'($urandom);
            if (rnd_mode) lat = $urandom_range(0, 3);
        end
    end

    // ---------------- Reference model ----------------
    typedef struct {
        bit                valid;
        int                who;
        bit                we;
        int                age;
    } txn_t;

    txn_t              cur;
    bit                bubble;
    int                ptr;
    logic [N_REQ-1:0]  e_done;
    logic [DATA_W-1:0] e_rdata, e_wdata;
    logic [ADDR_W-1:0] e_addr;
    logic              e_we, e_err;

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int w;
        bit fin;
        bit abort;
        e_done = '0;
        if (reset) begin
            cur.valid = 0;
            bubble    = 0;
            ptr       = 0;
            e_rdata   = '0;
            e_wdata   = '0;
            e_addr    = '0;
            e_we      = 1'b0;
            e_err     = 1'b0;
        end else if (bubble) begin
            bubble = 0;
        end else if (cur.valid) begin
            fin   = (mem_done === 1'b1);
            abort = 0;
`ifdef RAM_ARB_TIMEOUT_EN
            cur.age++;
            if (!fin && cur.age >= TIMEOUT_CYC) abort = 1;
`endif
            if (fin || abort) begin
                e_done[cur.who] = 1'b1;
                if (fin && !cur.we) e_rdata = mem_rdata;
                if (abort) e_err = 1'b1;
                ptr       = (cur.who + 1) % N_REQ;
                cur.valid = 0;
                bubble    = 1;
            end
        end else begin
            w = rr_pick(req, ptr);
            if (w >= 0) begin
                cur.valid = 1;
                cur.who   = w;
                cur.we    = req_we[w];
                cur.age   = 0;
                e_we      = req_we[w];
                e_addr    = req_addr[w*ADDR_W +: ADDR_W];
                e_wdata   = req_wdata[w*DATA_W +: DATA_W];
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N_REQ-1:0] eg;
        if (chk_en) begin
            eg = '0;
            if (cur.valid) eg[cur.who] = 1'b1;
            check("gnt", gnt, eg);
            check("done", done, e_done);
            check("busy", busy, cur.valid || bubble);
            check("mem_en", mem_en, cur.valid);
            check("mem_we", mem_we, e_we);
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
            check("rdata", rdata, e_rdata);
            check("err", err, e_err);
        end
    end

    // ---------------- Random requesters ----------------
    task automatic new_ops(input int i);
        req_we[i]                    = $urandom_range(0, 1);
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
        req_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    always @(negedge clk) begin
        if (rnd_mode) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) begin
                    if (done[i]) begin
                        if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
                        else new_ops(i);
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    new_ops(i);
                end
            end
        end
    end

    // ---------------- Directed helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int budget, input string tag);
        int n = 0;
        while (done[idx] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done[idx], 1'b1);
    endtask

    task automatic wait_gnt(input logic [N_REQ-1:0] mask, input int budget, input string tag);
        int n = 0;
        while (gnt !== mask && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_gnt_seen"}, gnt, mask);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int order[$];
        int done_cyc[$];
        int n;
        logic [N_REQ-1:0] prev_gnt;

        reset     = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        tick();
        chk_en = 1;
        tick();
        check("reset_gnt", gnt, 3'b000);
        check("reset_mem_en", mem_en, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_rdata", rdata, 16'h0000);
        reset = 1'b0;

        // 1: single read with a slow RAM
        ram[16'd50692] = 16'h0123;
        lat = 3;
        req_we[0]           = 1'b0;
        req_addr[0 +: 16]   = 16'd50692;
        req                 = 3'b001;
        tick();
        check("t1_mem_en_next_edge", mem_en, 1'b1);
        check("t1_gnt", gnt, 3'b001);
        check("t1_mem_addr", mem_addr, 16'd50692);
        check("t1_mem_we", mem_we, 1'b0);
        wait_done(0, 10, "t1");
        check("t1_rdata", rdata, 16'h0123);
        req = '0;
        n = 0;
        repeat (6) begin
            tick();
            if (done !== 3'b000) n++;
        end
        check("t1_single_done", n, 0);

        // 2: full contention, RAM answers in the first access cycle
        do_reset();
        lat = 0;
        req_we = '0;
        for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i + 3);
        req = 3'b111;
        prev_gnt = '0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (gnt !== 3'b000 && gnt !== prev_gnt) begin
                for (int i = 0; i < N_REQ; i++) if (gnt[i]) order.push_back(i);
            end
            prev_gnt = gnt;
            if (done !== 3'b000) begin
                done_cyc.push_back(c);
                check("t2_release_mem_en", mem_en, 1'b0);
            end
        end
        check("t2_grant_count", order.size() >= 4, 1'b1);
        if (order.size() >= 4) begin
            check("t2_order0", order[0], 0);
            check("t2_order1", order[1], 1);
            check("t2_order2", order[2], 2);
            check("t2_order3", order[3], 0);
        end
        for (int k = 1; k < done_cyc.size(); k++) begin
            check("t2_done_spacing", done_cyc[k] - done_cyc[k-1], 3);
        end
        req = '0;
        tick(4);

        // 3: write from requester 1, read back by requester 2
        lat = 1;
        req_we[1]          = 1'b1;
        req_addr[16 +: 16] = 16'd57596;
        req_wdata[16 +: 16] = 16'hFFF0;
        req = 3'b010;
        wait_gnt(3'b010, 4, "t3w");
        check("t3_mem_we_write", mem_we, 1'b1);
        wait_done(1, 10, "t3w");
        req_we[2]          = 1'b0;
        req_addr[32 +: 16] = 16'd57596;
        req = 3'b100;
        wait_gnt(3'b100, 6, "t3r");
        check("t3_mem_we_read", mem_we, 1'b0);
        check("t3_mem_addr", mem_addr, 16'd57596);
        wait_done(2, 10, "t3r");
        check("t3_rdata", rdata, 16'hFFF0);
        req = '0;
        tick(3);

        // 4: requester drops its request mid-access
        lat = 2;
        ram[16'd100]      = 16'h7A5C;
        req_we[0]         = 1'b0;
        req_addr[0 +: 16] = 16'd100;
        req = 3'b001;
        wait_gnt(3'b001, 6, "t4");
        tick();
        req = 3'b000;
        wait_done(0, 10, "t4");
        check("t4_rdata", rdata, 16'h7A5C);
        n = 0;
        repeat (6) begin
            tick();
            if (gnt !== 3'b000) n++;
        end
        check("t4_no_regrant", n, 0);

        // 5: reset while an access is outstanding
        hang = 1;
        req = 3'b001;
        wait_gnt(3'b001, 6, "t5a");
        tick();
        reset = 1'b1;
        req   = 3'b000;
        tick();
        check("t5_mem_en", mem_en, 1'b0);
        check("t5_gnt", gnt, 3'b000);
        check("t5_done", done, 3'b000);
        reset = 1'b0;
        hang  = 0;
        lat   = 0;
        req_we[2] = 1'b0;
        req = 3'b100;
        wait_gnt(3'b100, 4, "t5b");
        wait_done(2, 6, "t5b");
        req = '0;
        tick(3);

`ifdef RAM_ARB_TIMEOUT_EN
        // 6: watchdog abort when the RAM never answers
        do_reset();
        hang = 1;
        req = 3'b001;
        wait_gnt(3'b001, 4, "t6");
        n = 1;
        while (mem_en === 1'b1 && n < 40) begin
            tick();
            if (mem_en === 1'b1) n++;
        end
        check("t6_access_cycles", n, TIMEOUT_CYC);
        check("t6_done", done, 3'b001);
        check("t6_err", err, 1'b1);
        req = '0;
        hang = 0;
        tick(4);
        check("t6_err_sticky", err, 1'b1);
        do_reset();
        check("t6_err_cleared", err, 1'b0);
`endif

        // Randomized traffic with mem_done/mem_rdata noise outside accesses
        do_reset();
        noise    = 1;
        rnd_mode = 1;
        tick(3000);
        rnd_mode = 0;
        req      = '0;
        tick(12);
        noise = 0;
        tick(4);
        check("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
